// File: rtl/comparator_serial_nbit_if.sv
// Start/busy/done handshake and operand/result bundle for the serial magnitude comparator.
interface comparator_serial_nbit_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sgn;
    logic             busy;
    logic             done;
    logic             e;
    logic             g;
    logic             l;

    modport master (
        output start, a, b, sgn,
        input  busy, done, e, g, l
    );

    modport slave (
        input  start, a, b, sgn,
        output busy, done, e, g, l
    );
endinterface

// File: rtl/comparator_serial_nbit.sv
// Multi-cycle MSB-first magnitude comparator, DIGIT bits per clock, signed or unsigned.
// Optional feature: define COMPARATOR_EARLY_EXIT_EN to finish on the first unequal digit.
module comparator_serial_nbit #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 2
) (
    input logic                     clk,
    input logic                     rst_n,
    comparator_serial_nbit_if.slave bus
);

    localparam int unsigned NUM_DIGITS = WIDTH / DIGIT;
    localparam int unsigned IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

    generate
        if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
            $error("comparator_serial_nbit: DIGIT must divide WIDTH");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        DEC_NONE = 2'd0,
        DEC_G    = 2'd1,
        DEC_L    = 2'd2
    } dec_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    dec_t             dec_q, dec_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             e_q, e_d;
    logic             g_q, g_d;
    logic             l_q, l_d;

    logic [DIGIT-1:0] digit_a;
    logic [DIGIT-1:0] digit_b;
    dec_t             dec_cur;
    logic             finish;

    // Current digit slice and the sticky decision including this digit
    always_comb begin
        digit_a = DIGIT'(a_q >> (32'(idx_q) * DIGIT));
        digit_b = DIGIT'(b_q >> (32'(idx_q) * DIGIT));
        dec_cur = dec_q;
        if (dec_q == DEC_NONE) begin
            if (digit_a > digit_b) begin
                dec_cur = DEC_G;
            end else if (digit_a < digit_b) begin
                dec_cur = DEC_L;
            end
        end
`ifdef COMPARATOR_EARLY_EXIT_EN
        finish = (idx_q == '0) || (dec_cur != DEC_NONE);
`else
        finish = (idx_q == '0);
`endif
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            dec_q   <= DEC_NONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            e_q     <= 1'b0;
            g_q     <= 1'b0;
            l_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            dec_q   <= dec_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            e_q     <= e_d;
            g_q     <= g_d;
            l_q     <= l_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.start) state_d = RUN;
            RUN:  if (finish)    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output next values; signed operands are mapped to offset binary on capture
    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        idx_d  = idx_q;
        dec_d  = dec_q;
        busy_d = busy_q;
        done_d = 1'b0;
        e_d    = e_q;
        g_d    = g_q;
        l_d    = l_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d    = bus.sgn ? (bus.a ^ MSB_MASK) : bus.a;
                    b_d    = bus.sgn ? (bus.b ^ MSB_MASK) : bus.b;
                    idx_d  = IDX_LAST;
                    dec_d  = DEC_NONE;
                    busy_d = 1'b1;
                end
            end
            RUN: begin
                dec_d = dec_cur;
                if (finish) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                    e_d    = (dec_cur == DEC_NONE);
                    g_d    = (dec_cur == DEC_G);
                    l_d    = (dec_cur == DEC_L);
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.e    = e_q;
    assign bus.g    = g_q;
    assign bus.l    = l_q;

endmodule

// File: tb/tb_comparator_serial_nbit.sv
// Scoreboard bench for comparator_serial_nbit: 8-bit/2-bit-digit instance plus an exhaustive 2-bit/1-bit instance.
module tb_comparator_serial_nbit;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    comparator_serial_nbit_if #(.WIDTH(8)) bus8 ();
    comparator_serial_nbit_if #(.WIDTH(2)) bus2 ();

    comparator_serial_nbit #(.WIDTH(8), .DIGIT(2)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8.slave)
    );

    comparator_serial_nbit #(.WIDTH(2), .DIGIT(1)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2.slave)
    );

    typedef struct {
        logic [2:0] egl;
        int         lat;
        int         t0;
    } exp_t;

    exp_t q8[$];
    exp_t q2[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference compare on integer values; returns {e,g,l}
    function automatic logic [2:0] ref_cmp(input int w, input logic [7:0] a, input logic [7:0] b,
                                           input logic s);
        int va;
        int vb;
        va = int'(a);
        vb = int'(b);
        if (s && a[w-1]) va = va - (1 << w);
        if (s && b[w-1]) vb = vb - (1 << w);
        if (va == vb) return 3'b100;
        if (va > vb)  return 3'b010;
        return 3'b001;
    endfunction

    function automatic int ref_lat(input int w, input int d, input logic [7:0] a, input logic [7:0] b);
`ifdef COMPARATOR_EARLY_EXIT_EN
        int x;
        x = int'(a ^ b);
        for (int i = w / d - 1; i >= 0; i--) begin
            if (((x >> (i * d)) & ((1 << d) - 1)) != 0) return w / d - i;
        end
`endif
        return w / d;
    endfunction

    // Output monitors: pop expected results when done pulses
    always @(negedge clk) begin
        exp_t x;
        if (rst_n && bus8.done) begin
            if (q8.size() == 0) begin
                check("d8_spurious_done", 32'd1, 32'd0);
            end else begin
                x = q8.pop_front();
                check("d8_egl", {29'd0, bus8.e, bus8.g, bus8.l}, {29'd0, x.egl});
                check("d8_latency", cyc - x.t0, x.lat);
                check("d8_busy_at_done", {31'd0, bus8.busy}, 32'd0);
            end
        end
    end

    always @(negedge clk) begin
        exp_t x;
        if (rst_n && bus2.done) begin
            if (q2.size() == 0) begin
                check("d2_spurious_done", 32'd1, 32'd0);
            end else begin
                x = q2.pop_front();
                check("d2_egl", {29'd0, bus2.e, bus2.g, bus2.l}, {29'd0, x.egl});
                check("d2_onehot", 32'(bus2.e) + 32'(bus2.g) + 32'(bus2.l), 32'd1);
                check("d2_latency", cyc - x.t0, x.lat);
            end
        end
    end

    // Called at a negedge with the DUT idle or in its done cycle
    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic s);
        logic [2:0] prev;
        exp_t       x;
        prev = {bus8.e, bus8.g, bus8.l};
        bus8.a = a;
        bus8.b = b;
        bus8.sgn = s;
        bus8.start = 1'b1;
        x.egl = ref_cmp(8, a, b, s);
        x.lat = ref_lat(8, 2, a, b);
        x.t0  = cyc + 1;
        q8.push_back(x);
        @(negedge clk);
        bus8.start = 1'b0;
        bus8.a = 8'($urandom);
        bus8.b = 8'($urandom);
        bus8.sgn = 1'($urandom);
        check("d8_result_hold", {29'd0, bus8.e, bus8.g, bus8.l}, {29'd0, prev});
        check("d8_busy_run", {31'd0, bus8.busy}, 32'd1);
    endtask

    task automatic issue2(input logic [1:0] a, input logic [1:0] b, input logic s);
        exp_t x;
        bus2.a = a;
        bus2.b = b;
        bus2.sgn = s;
        bus2.start = 1'b1;
        x.egl = ref_cmp(2, {6'd0, a}, {6'd0, b}, s);
        x.lat = ref_lat(2, 1, {6'd0, a}, {6'd0, b});
        x.t0  = cyc + 1;
        q2.push_back(x);
        @(negedge clk);
        bus2.start = 1'b0;
        bus2.a = 2'($urandom);
        bus2.b = 2'($urandom);
    endtask

    task automatic drain(input bit use8);
        int n;
        n = 0;
        while (((use8 ? q8.size() : q2.size()) != 0) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(use8 ? "d8_drain" : "d2_drain", use8 ? q8.size() : q2.size(), 32'd0);
    endtask

    logic [7:0] va[6] = '{8'hA5, 8'h80, 8'h80, 8'hFF, 8'hC0, 8'h41};
    logic [7:0] vb[6] = '{8'hA5, 8'h7F, 8'h7F, 8'h01, 8'h40, 8'h42};
    logic       vs[6] = '{1'b0,  1'b0,  1'b1,  1'b1,  1'b0,  1'b0};

    initial begin
        exp_t x;
        int   n;
        rst_n = 1'b0;
        bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.sgn = 1'b0;
        bus2.start = 1'b0; bus2.a = '0; bus2.b = '0; bus2.sgn = 1'b0;
        #12;
        check("rst_busy", {31'd0, bus8.busy}, 32'd0);
        check("rst_done", {31'd0, bus8.done}, 32'd0);
        check("rst_egl",  {29'd0, bus8.e, bus8.g, bus8.l}, 32'd0);
        check("rst2_egl", {29'd0, bus2.e, bus2.g, bus2.l}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors, then random signed/unsigned
        for (int i = 0; i < 6; i++) begin
            issue8(va[i], vb[i], vs[i]);
            drain(1'b1);
        end
        for (int i = 0; i < 20; i++) begin
            issue8(8'($urandom), 8'($urandom), 1'($urandom));
            drain(1'b1);
        end

        // start held through busy, operands scrambled mid-run
        bus8.a = 8'h12; bus8.b = 8'h13; bus8.sgn = 1'b0; bus8.start = 1'b1;
        x.egl = 3'b001; x.lat = 4; x.t0 = cyc + 1;
        q8.push_back(x);
        repeat (4) begin
            @(negedge clk);
            bus8.a = 8'($urandom);
            bus8.b = 8'($urandom);
            bus8.sgn = 1'($urandom);
        end
        bus8.start = 1'b0;
        drain(1'b1);
        repeat (6) @(negedge clk);

        // Back-to-back: start in the done cycle
        issue8(8'h3C, 8'h3D, 1'b0);
        n = 0;
        while (!bus8.done && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("d8_b2b_done_seen", {31'd0, bus8.done}, 32'd1);
        issue8(8'hF0, 8'h0F, 1'b1);
        drain(1'b1);

        // Exhaustive small instance
        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++)
                for (int s = 0; s < 2; s++) begin
                    issue2(2'(a), 2'(b), 1'(s));
                    drain(1'b0);
                end

        // Asynchronous reset after edge 2 of a compare
        issue8(8'h12, 8'h34, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, bus8.busy}, 32'd0);
        check("arst_done", {31'd0, bus8.done}, 32'd0);
        check("arst_egl",  {29'd0, bus8.e, bus8.g, bus8.l}, 32'd0);
        check("arst2_egl", {29'd0, bus2.e, bus2.g, bus2.l}, 32'd0);
        q8.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("arst_no_result", {29'd0, bus8.e, bus8.g, bus8.l}, 32'd0);

        issue8(8'h00, 8'hFF, 1'b1);
        drain(1'b1);
        check("q2_empty", q2.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/comparator_serial_nbit.md
Name: comparator_serial_nbit

Overview:
- Parametrised, sequential magnitude comparator. It is the multi-cycle successor to the 2-bit data-flow comparator.
- Compares two WIDTH-bit operands MSB-first, one DIGIT-bit slice per clock, in signed or unsigned mode.
- Produces registered equal, greater and less flags with a start/busy/done handshake.
- Used wherever wide compares must not sit in a single combinational path.

Parameters:
- WIDTH, 8: operand width in bits.
- DIGIT, 2: bits compared per clock. Must divide WIDTH; elaboration fails otherwise.
- NUM_DIGITS is derived as WIDTH/DIGIT; it is not overridable.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- a  in  WIDTH  operand A; captured at the accepting edge.
- b  in  WIDTH  operand B; captured at the accepting edge.
- sgn  in  1  1 = two's-complement compare, 0 = unsigned; captured with the operands.
- busy  out  1  high while a compare is in progress.
- done  out  1  one-cycle pulse; e/g/l valid from this cycle.
- e  out  1  a == b.
- g  out  1  a > b.
- l  out  1  a < b.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset state: state=IDLE; busy=0, done=0, e=0, g=0, l=0; capture registers and digit index cleared.
- Reset mid-compare: abort immediately; no done pulse; outputs return to their reset values.
- State machine has two states, IDLE and RUN.
- IDLE:
  - start=1 at an edge captures a, b and sgn; sets idx=NUM_DIGITS-1 and busy=1; moves to RUN.
  - When sgn=1, the MSB of both captured operands is inverted (offset binary), so the datapath is unsigned only.
- RUN, each edge:
  - Compare digit idx of captured A and B (bits idx*DIGIT+DIGIT-1 : idx*DIGIT).
  - A decision is held in a sticky register.
  - The first unequal digit sets the decision to G (A digit > B digit) or L. Later digits never override it.
  - All digits equal → decision is E.
  - Completion edge: e/g/l load the decision (exactly one high); done=1; busy=0; state→IDLE.
  - Otherwise idx decrements.
- Latency:
  - Start edge counts as edge 0.
  - Completion occurs at edge NUM_DIGITS, fixed (see Optional Feature for the exception).
- Result hold: e/g/l hold their value until the next completion. They are not cleared by start.
- Handshake:
  - done is high for exactly one cycle.
  - start while busy=1 is ignored; operands are not re-captured.
  - start high in the done cycle (state IDLE) is accepted, giving back-to-back throughput of one compare per NUM_DIGITS+1 cycles.
- Before the first completion after reset, e=g=l=0; this means "no result".
- Operands a, b and sgn may change freely after the start edge without affecting the compare in progress.

Optional Feature:
- Macro: COMPARATOR_EARLY_EXIT_EN.
- Defined:
  - RUN completes on the first unequal digit.
  - Completion edge is k, where k is the 1-based position of the first differing digit from the MSB, or NUM_DIGITS if the operands are equal.
- Undefined:
  - Always runs NUM_DIGITS cycles.
  - Latency is constant and data-independent (timing-safe).
- Results are identical in both builds.

Test Plan (WIDTH=8, DIGIT=2 unless stated):
- Equal operands: a=0xA5, b=0xA5, sgn=0, start pulse → done at edge 4; e=1, g=0, l=0; busy high for edges 1–4.
- Sign mode: a=0x80, b=0x7F. With sgn=0 → g=1. With sgn=1 → l=1 (−128 < 127). a=0xFF, b=0x01, sgn=1 → l=1.
- Early exit: a=0xC0, b=0x40.
  - With COMPARATOR_EARLY_EXIT_EN: done at edge 1, g=1.
  - Without: done at edge 4, g=1.
  - a=0x41, b=0x42 → l=1 at edge 4 in both builds.
- Handshake:
  - start held high through busy, with a/b changed mid-run → single done; result reflects the originally captured operands.
  - start asserted in the done cycle → new compare accepted; next done NUM_DIGITS edges later.
- Reset: rst_n low asynchronously at edge 2 of a compare → busy=0, done=0, e=g=l=0 immediately; no done pulse follows.
- Exhaustive: WIDTH=2, DIGIT=1, all 16 {a,b} pairs × sgn∈{0,1} → e/g/l match the reference model; exactly one flag high per done.
